// File: rtl/gradient_tx_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gradient_tx_packer
//  Purpose  : Packs 32-bit gradient words into 512-bit TCP TX lines and issues
//             one session metadata word per TCP packet (splits long batches).
//  Revision : 1.0
// ============================================================================
module gradient_tx_packer #(
    parameter int WORD_BITS  = 32,
    parameter int LINE_WORDS = 16,
    parameter int MAX_LINES  = 22,
    parameter int SESS_BITS  = 16
) (
    input  logic                                clk,
    input  logic                                aresetn,
    input  logic                                s_grad_valid,
    output logic                                s_grad_ready,
    input  logic [WORD_BITS-1:0]                s_grad_data,
    input  logic                                s_grad_last,
    input  logic                                s_sess_valid,
    output logic                                s_sess_ready,
    input  logic [63:0]                         s_sess_data,
    output logic                                m_tx_meta_valid,
    input  logic                                m_tx_meta_ready,
    output logic [SESS_BITS-1:0]                m_tx_meta_data,
    output logic                                m_tx_data_valid,
    input  logic                                m_tx_data_ready,
    output logic [WORD_BITS*LINE_WORDS-1:0]     m_tx_data_data,
    output logic [WORD_BITS*LINE_WORDS/8-1:0]   m_tx_data_keep,
    output logic                                m_tx_data_last,
    output logic [31:0]                         pkt_count
);

    localparam int c_line_bits  = WORD_BITS * LINE_WORDS;
    localparam int c_keep_bits  = c_line_bits / 8;
    localparam int c_word_bytes = WORD_BITS / 8;
    localparam int c_idx_w      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int c_cnt_w      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_meta = 2'd1;
    localparam logic [1:0] c_st_fill = 2'd2;
    localparam logic [1:0] c_st_send = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [SESS_BITS-1:0]   r_sess;
    logic [c_cnt_w-1:0]     r_line_cnt;
    logic [c_idx_w-1:0]     r_word_idx;
    logic [c_line_bits-1:0] r_data;
    logic [c_keep_bits-1:0] r_keep;
    logic                   r_batch_end;
    logic [31:0]            r_pkt_count;

    logic w_forced;
    logic w_fill_last;
    logic w_fill_hs;
    logic w_send_hs;
    logic w_unused_sess;

    // Upper session-record bits carry nothing this block needs.
    assign w_unused_sess = ^s_sess_data[63:SESS_BITS];

    assign w_forced    = (r_line_cnt == c_cnt_w'(MAX_LINES - 1));
    assign w_fill_last = (r_word_idx == c_idx_w'(LINE_WORDS - 1)) || s_grad_last;
    assign w_fill_hs   = (r_state == c_st_fill) && s_grad_valid;
    assign w_send_hs   = (r_state == c_st_send) && m_tx_data_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (s_sess_valid)    w_state_nxt = c_st_meta;
            c_st_meta: if (m_tx_meta_ready) w_state_nxt = c_st_fill;
            c_st_fill: if (w_fill_hs && w_fill_last) w_state_nxt = c_st_send;
            c_st_send: begin
                if (m_tx_data_ready) begin
                    if (r_batch_end)   w_state_nxt = c_st_idle;
                    else if (w_forced) w_state_nxt = c_st_meta;
                    else               w_state_nxt = c_st_fill;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode
    always_comb begin
        s_grad_ready    = 1'b0;
        m_tx_meta_valid = 1'b0;
        m_tx_data_valid = 1'b0;
        m_tx_data_last  = 1'b0;
        s_sess_ready    = 1'b0;
        case (r_state)
            c_st_meta: m_tx_meta_valid = 1'b1;
            c_st_fill: s_grad_ready    = 1'b1;
            c_st_send: begin
                m_tx_data_valid = 1'b1;
                m_tx_data_last  = r_batch_end || w_forced;
                // The session record is released only once its final line leaves.
                s_sess_ready    = r_batch_end && m_tx_data_ready;
            end
            default: ;
        endcase
    end

    // Datapath: session latch, line assembly and counters
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_sess      <= '0;
            r_line_cnt  <= '0;
            r_word_idx  <= '0;
            r_data      <= '0;
            r_keep      <= '0;
            r_batch_end <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if ((r_state == c_st_idle) && s_sess_valid) begin
                r_sess     <= s_sess_data[SESS_BITS-1:0];
                r_line_cnt <= '0;
            end
            if (w_fill_hs) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (r_word_idx == c_idx_w'(i)) begin
                        r_data[i*WORD_BITS +: WORD_BITS]      <= s_grad_data;
                        r_keep[i*c_word_bytes +: c_word_bytes] <= '1;
                    end
                end
                r_word_idx <= r_word_idx + 1'b1;
                if (w_fill_last) begin
                    r_batch_end <= s_grad_last;
                end
            end
            if (w_send_hs) begin
                r_word_idx  <= '0;
                r_data      <= '0;
                r_keep      <= '0;
                r_batch_end <= 1'b0;
                if (r_batch_end || w_forced) begin
                    r_line_cnt  <= '0;
                    r_pkt_count <= r_pkt_count + 32'd1;
                end else begin
                    r_line_cnt  <= r_line_cnt + 1'b1;
                end
            end
        end
    end

    assign m_tx_meta_data = r_sess;
    assign m_tx_data_data = r_data;
    assign m_tx_data_keep = r_keep;
    assign pkt_count      = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_gradient_tx_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gradient_tx_packer
//  Purpose  : Randomized self-checking bench for gradient_tx_packer against a
//             batch-level model of lines, packets and session usage.
//  Revision : 1.0
// ============================================================================
module tb_gradient_tx_packer;

    localparam int LW = 16;
    localparam int ML = 22;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_grad_valid = 1'b0;
    logic         s_grad_ready;
    logic [31:0]  s_grad_data = '0;
    logic         s_grad_last = 1'b0;
    logic         s_sess_valid = 1'b0;
    logic         s_sess_ready;
    logic [63:0]  s_sess_data = '0;
    logic         m_tx_meta_valid;
    logic         m_tx_meta_ready = 1'b0;
    logic [15:0]  m_tx_meta_data;
    logic         m_tx_data_valid;
    logic         m_tx_data_ready = 1'b0;
    logic [511:0] m_tx_data_data;
    logic [63:0]  m_tx_data_keep;
    logic         m_tx_data_last;
    logic [31:0]  pkt_count;

    gradient_tx_packer dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .s_grad_valid    (s_grad_valid),
        .s_grad_ready    (s_grad_ready),
        .s_grad_data     (s_grad_data),
        .s_grad_last     (s_grad_last),
        .s_sess_valid    (s_sess_valid),
        .s_sess_ready    (s_sess_ready),
        .s_sess_data     (s_sess_data),
        .m_tx_meta_valid (m_tx_meta_valid),
        .m_tx_meta_ready (m_tx_meta_ready),
        .m_tx_meta_data  (m_tx_meta_data),
        .m_tx_data_valid (m_tx_data_valid),
        .m_tx_data_ready (m_tx_data_ready),
        .m_tx_data_data  (m_tx_data_data),
        .m_tx_data_keep  (m_tx_data_keep),
        .m_tx_data_last  (m_tx_data_last),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         fin;
    } line_t;

    line_t       exp_lines[$];
    logic [15:0] exp_meta[$];
    logic [63:0] sess_fifo[$];

    int vectors = 0;
    int miscompares = 0;
    int bp_pct = 0;
    int gap_pct = 0;
    int pops = 0;
    int meta_total = 0;
    int meta_hs = 0;
    int data_pkts = 0;
    int exp_pkts = 0;
    bit pop_pending = 0;
    bit rst_seen = 0;

    logic [511:0] obs_data;
    logic [63:0]  obs_keep;
    logic         obs_last;

    logic         prev_mv, prev_mr, prev_dv, prev_dr, prev_dl;
    logic [15:0]  prev_md;
    logic [511:0] prev_dd;
    logic [63:0]  prev_dk;
    line_t        cur;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected lines/metas for one batch, derived from word count alone.
    task automatic model_batch(input logic [15:0] sess, input logic [31:0] w[$]);
        int n;
        int nl;
        line_t e;
        n  = w.size();
        nl = (n + LW - 1) / LW;
        for (int l = 0; l < nl; l++) begin
            if (l % ML == 0) exp_meta.push_back(sess);
            e.data = '0;
            e.keep = '0;
            for (int k = 0; k < LW; k++) begin
                if (l * LW + k < n) begin
                    e.data[k*32 +: 32] = w[l*LW + k];
                    e.keep[k*4 +: 4]   = 4'hF;
                end
            end
            e.fin  = (l == nl - 1);
            e.last = e.fin || ((l + 1) % ML == 0);
            exp_lines.push_back(e);
        end
    endtask

    task automatic drive_words(input logic [31:0] w[$], input int n);
        bit hs;
        int g;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            s_grad_valid = 1'b1;
            s_grad_data  = w[i];
            s_grad_last  = (i == w.size() - 1);
            hs = 0;
            g  = 0;
            while (!hs && g < 3000) begin
                @(negedge clk);
                hs = s_grad_ready;
                @(posedge clk); #1;
                g++;
            end
            s_grad_valid = 1'b0;
            s_grad_last  = 1'b0;
            if (!hs) begin
                check("grad_accept_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_lines.size() != 0 || exp_meta.size() != 0 || sess_fifo.size() != 0) && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check("drain_timeout", g < 5000, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Session FIFO source and output back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pop_pending && sess_fifo.size() != 0) void'(sess_fifo.pop_front());
            pop_pending = 0;
            s_sess_valid = (sess_fifo.size() != 0);
            s_sess_data  = (sess_fifo.size() != 0) ? sess_fifo[0] : 64'd0;
            m_tx_meta_ready = ($urandom_range(99) >= bp_pct);
            m_tx_data_ready = ($urandom_range(99) >= bp_pct);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!aresetn) begin
            rst_seen  = 1;
            meta_hs   = 0;
            data_pkts = 0;
            exp_pkts  = 0;
            prev_mv   = 0;
            prev_dv   = 0;
            prev_mr   = 0;
            prev_dr   = 0;
        end else begin
            if (rst_seen) begin
                check("reset_outputs",
                      {s_grad_ready, s_sess_ready, m_tx_meta_valid, m_tx_meta_data,
                       m_tx_data_valid, m_tx_data_last, m_tx_data_keep, pkt_count},
                      '0);
                check("reset_data", m_tx_data_data, '0);
                rst_seen = 0;
            end
            check("pkt_count", pkt_count, exp_pkts);
            if (prev_mv && !prev_mr)
                check("meta_stable", {m_tx_meta_valid, m_tx_meta_data}, {1'b1, prev_md});
            if (prev_dv && !prev_dr)
                check("data_stable", {m_tx_data_valid, m_tx_data_last, m_tx_data_keep, m_tx_data_data},
                      {1'b1, prev_dl, prev_dk, prev_dd});
            if (m_tx_meta_valid && m_tx_meta_ready) begin
                if (exp_meta.size() == 0) check("meta_unexpected", 1, 0);
                else check("meta_data", m_tx_meta_data, exp_meta.pop_front());
                meta_hs++;
                meta_total++;
            end
            if (m_tx_data_valid && m_tx_data_ready) begin
                check("meta_before_data", meta_hs > data_pkts, 1);
                if (exp_lines.size() == 0) begin
                    check("line_unexpected", 1, 0);
                end else begin
                    cur = exp_lines.pop_front();
                    check("line_data", m_tx_data_data, cur.data);
                    check("line_keep", m_tx_data_keep, cur.keep);
                    check("line_last", m_tx_data_last, cur.last);
                    check("sess_pop", s_sess_ready, cur.fin);
                end
                obs_data = m_tx_data_data;
                obs_keep = m_tx_data_keep;
                obs_last = m_tx_data_last;
                if (m_tx_data_last) begin
                    data_pkts++;
                    exp_pkts++;
                end
            end else begin
                check("sess_pop_idle", s_sess_ready, 0);
            end
            if (s_sess_valid && s_sess_ready) begin
                pop_pending = 1;
                pops++;
            end
            prev_mv = m_tx_meta_valid;
            prev_mr = m_tx_meta_ready;
            prev_md = m_tx_meta_data;
            prev_dv = m_tx_data_valid;
            prev_dr = m_tx_data_ready;
            prev_dd = m_tx_data_data;
            prev_dk = m_tx_data_keep;
            prev_dl = m_tx_data_last;
        end
    end

    initial begin
        logic [31:0] w[$];
        int meta_before;
        int pops_before;
        int nw;

        repeat (4) @(posedge clk);
        #1 aresetn = 1'b1;

        // Full single line
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(i);
        sess_fifo.push_back({48'h1234_5678_9ABC, 16'h0042});
        model_batch(16'h0042, w);
        drive_words(w, w.size());
        wait_drain();
        check("t1_keep", obs_keep, {64{1'b1}});
        check("t1_lane15", obs_data[15*32 +: 32], 32'd15);
        check("t1_last", obs_last, 1'b1);
        check("t1_pkt_count", pkt_count, 32'd1);
        check("t1_pops", pops, 1);

        // Partial trailing line
        w.delete();
        for (int i = 0; i < 20; i++) w.push_back(i);
        sess_fifo.push_back({48'h0, 16'h0007});
        model_batch(16'h0007, w);
        drive_words(w, w.size());
        wait_drain();
        check("t2_keep", obs_keep, 64'h0000_0000_0000_FFFF);
        check("t2_lane3", obs_data[3*32 +: 32], 32'd19);
        check("t2_lane4", obs_data[4*32 +: 32], 32'd0);
        check("t2_pkt_count", pkt_count, 32'd2);

        // Forced split at MAX_LINES
        w.delete();
        for (int i = 0; i < 16 * 23; i++) w.push_back($urandom());
        meta_before = meta_total;
        sess_fifo.push_back({48'hFFFF_0000_FFFF, 16'h0007});
        model_batch(16'h0007, w);
        drive_words(w, w.size());
        wait_drain();
        check("t3_meta_count", meta_total - meta_before, 2);
        check("t3_pkt_count", pkt_count, 32'd4);
        check("t3_pops", pops, 3);
        check("t3_keep", obs_keep, {64{1'b1}});

        // Back-pressure with three queued sessions
        bp_pct  = 30;
        gap_pct = 20;
        for (int s = 1; s <= 3; s++) sess_fifo.push_back({32'($urandom()), 16'($urandom()), 16'(s)});
        for (int s = 1; s <= 3; s++) begin
            w.delete();
            nw = $urandom_range(60, 1);
            for (int i = 0; i < nw; i++) w.push_back($urandom());
            model_batch(16'(s), w);
            drive_words(w, w.size());
        end
        wait_drain();
        check("t4_pkt_count", pkt_count, 32'd7);
        check("t4_pops", pops, 6);
        bp_pct  = 0;
        gap_pct = 0;

        // Reset in the middle of a line
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back($urandom());
        sess_fifo.push_back({48'h0, 16'h00AB});
        exp_meta.push_back(16'h00AB);
        drive_words(w, 5);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        pops_before = pops;
        w.delete();
        for (int i = 0; i < 7; i++) w.push_back($urandom());
        model_batch(16'h00AB, w);
        drive_words(w, w.size());
        wait_drain();
        check("t5_pops", pops - pops_before, 1);
        check("t5_pkt_count", pkt_count, 32'd1);
        check("t5_keep", obs_keep, 64'h0000_0000_0FFF_FFFF);
        check("t5_lane0", obs_data[31:0], w[0]);

        // Last flag on the first word
        w.delete();
        w.push_back(32'hDEAD_BEEF);
        sess_fifo.push_back({48'h0, 16'h00CD});
        model_batch(16'h00CD, w);
        drive_words(w, w.size());
        wait_drain();
        check("t6_lane0", obs_data[31:0], 32'hDEAD_BEEF);
        check("t6_keep", obs_keep, 64'h0000_0000_0000_000F);
        check("t6_last", obs_last, 1'b1);
        check("t6_pkt_count", pkt_count, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
